// File: rtl/ru_debug_arbiter_if.sv
// Signal bundle between the core datapath, the debug requester, the register
// unit and the debug arbiter. The slave modport is the arbiter's view.
interface ru_debug_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] cpu_rs1;
    logic [ADDR_W-1:0] cpu_rs2;
    logic [ADDR_W-1:0] cpu_rd;
    logic              cpu_RUWr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_stall;

    logic              dbg_req;
    logic              dbg_we;
    logic [ADDR_W-1:0] dbg_addr;
    logic [DATA_W-1:0] dbg_wdata;
    logic              dbg_ack;
    logic [DATA_W-1:0] dbg_rdata;

    logic [ADDR_W-1:0] ru_rs1;
    logic [ADDR_W-1:0] ru_rs2;
    logic [ADDR_W-1:0] ru_rd;
    logic              ru_RUWr;
    logic [DATA_W-1:0] ru_wdata;
    logic [DATA_W-1:0] ru_rdata2;

    // Environment side: CPU, debug requester and register unit.
    modport master (
        output cpu_rs1, cpu_rs2, cpu_rd, cpu_RUWr, cpu_wdata,
        input  cpu_stall,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dbg_ack, dbg_rdata,
        input  ru_rs1, ru_rs2, ru_rd, ru_RUWr, ru_wdata,
        output ru_rdata2
    );

    modport slave (
        input  cpu_rs1, cpu_rs2, cpu_rd, cpu_RUWr, cpu_wdata,
        output cpu_stall,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dbg_ack, dbg_rdata,
        output ru_rs1, ru_rs2, ru_rd, ru_RUWr, ru_wdata,
        input  ru_rdata2
    );
endinterface

// File: rtl/ru_debug_arbiter.sv
// Shares the register unit write port and second read port between CPU
// writeback and a debug requester; debug writes steal idle write slots.
module ru_debug_arbiter #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    ru_debug_arbiter_if.slave   bus,
    output logic [1:0]          o_state
);
    localparam int CNT_W = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_STALL = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic              w_free;
    logic              w_starved;

    assign w_free    = !bus.cpu_RUWr || (bus.cpu_rd == '0);
    assign w_starved = (r_cnt == CNT_W'(STARVE_MAX - 1));

    assign bus.cpu_stall = (r_state == S_STALL);
    assign bus.dbg_ack   = (r_state == S_ACK);
    assign bus.dbg_rdata = r_rdata;
    assign bus.ru_rs1    = bus.cpu_rs1;
    assign o_state       = r_state;

    always_comb begin
        w_next       = r_state;
        bus.ru_rs2   = bus.cpu_rs2;
        bus.ru_rd    = bus.cpu_rd;
        bus.ru_RUWr  = bus.cpu_RUWr;
        bus.ru_wdata = bus.cpu_wdata;
        case (r_state)
            S_IDLE: begin
                if (bus.dbg_req) w_next = bus.dbg_we ? S_WAIT : S_STALL;
            end
            S_WAIT: begin
                if (w_free) begin
                    bus.ru_rd    = r_addr;
                    bus.ru_wdata = r_wdata;
                    bus.ru_RUWr  = (r_addr != '0);
                    w_next       = S_ACK;
                end else if (w_starved) begin
                    w_next = S_STALL;
                end
            end
            S_STALL: begin
                // CPU commit is suppressed here; it replays the instruction.
                bus.ru_rs2 = r_addr;
                if (r_we) begin
                    bus.ru_rd    = r_addr;
                    bus.ru_wdata = r_wdata;
                    bus.ru_RUWr  = (r_addr != '0);
                end else begin
                    bus.ru_RUWr = 1'b0;
                end
                w_next = S_ACK;
            end
            S_ACK:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.dbg_req) begin
                        r_we    <= bus.dbg_we;
                        r_addr  <= bus.dbg_addr;
                        r_wdata <= bus.dbg_wdata;
                        r_cnt   <= '0;
                    end
                end
                S_WAIT: begin
                    if (w_free) r_rdata <= r_wdata;
                    else if (!w_starved) r_cnt <= r_cnt + 1'b1;
                end
                S_STALL: r_rdata <= r_we ? r_wdata : bus.ru_rdata2;
                default: ;
            endcase
        end
    end
endmodule

// File: doc/ru_debug_arbiter.md
Name: ru_debug_arbiter

Overview:
- Shares the register unit's write port and second read port between CPU writeback and a debug requester (switch/UART console, VGA register-viewer editor).
- Debug writes slip into cycles where the CPU commits no write.
- Debug reads, and writes starved beyond a bound, stall the CPU for exactly one cycle.
- Sits between the core datapath (decode/writeback) and the register unit.

Parameters:
- ADDR_W, 5, register index width.
- DATA_W, 32, register data width.
- STARVE_MAX, 8, maximum number of WAIT cycles a pending debug write waits before forcing a stall (must be ≥1).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- cpu_rs1  input  ADDR_W  CPU read index 1 (passed through)
- cpu_rs2  input  ADDR_W  CPU read index 2
- cpu_rd  input  ADDR_W  CPU write index
- cpu_RUWr  input  1  CPU write enable
- cpu_wdata  input  DATA_W  CPU write data
- cpu_stall  output  1  CPU holds PC and suppresses commit this cycle
- dbg_req  input  1  debug transaction request
- dbg_we  input  1  1 = write, 0 = read
- dbg_addr  input  ADDR_W  debug register index
- dbg_wdata  input  DATA_W  debug write data
- dbg_ack  output  1  one-cycle completion pulse
- dbg_rdata  output  DATA_W  read result, valid from the ack cycle onward
- ru_rs1, ru_rs2, ru_rd  output  ADDR_W  to register unit
- ru_RUWr  output  1  to register unit
- ru_wdata  output  DATA_W  to register unit
- ru_rdata2  input  DATA_W  register unit output_rs2

Behaviour:
- Reset (rst_n low at posedge): state IDLE; starve counter 0; dbg_ack 0; dbg_rdata 0; cpu_stall 0; holding regs 0. Reset mid-transaction aborts silently: no ack, no write.
- FSM states: IDLE, WAIT, STALL, ACK. cpu_stall = (state == STALL); dbg_ack = (state == ACK). Both are decoded from the state flop only, never from inputs.
- Default mux: ru_rs1 = cpu_rs1 always; ru_rs2 = cpu_rs2; ru_rd = cpu_rd; ru_RUWr = cpu_RUWr; ru_wdata = cpu_wdata.
- IDLE:
  - dbg_req = 1 latches dbg_we, dbg_addr and dbg_wdata into holding regs and clears the starve counter.
  - Next state is WAIT if the op is a write, STALL if it is a read.
  - Debug inputs are ignored in all other states.
- WAIT (write pending):
  - The slot is free when cpu_RUWr == 0 or cpu_rd == 0.
  - Free slot, same cycle: ru_rd = held addr, ru_wdata = held data, ru_RUWr = (held addr != 0). Next state ACK. No stall.
  - Busy slot: CPU keeps the port. If counter == STARVE_MAX-1, next state is STALL; otherwise the counter increments.
  - Result: at most STARVE_MAX WAIT cycles.
- STALL:
  - The CPU write is blocked; debug owns the port.
  - ru_rs2 = held addr.
  - Write op: ru_rd/ru_wdata from the holding regs; ru_RUWr = (held addr != 0).
  - Read op: ru_RUWr = 0.
  - At the posedge: read op captures dbg_rdata <= ru_rdata2; write op sets dbg_rdata <= held data.
  - Next state ACK.
- WAIT steal with a write op: dbg_rdata <= held data on the transition to ACK.
- ACK: one-cycle pulse, then IDLE. A still-high dbg_req is resampled in IDLE, so back-to-back transactions take at least 3 cycles each.
- Latency from the req-sampling edge:
  - write with free slot: ack in 2nd cycle;
  - read: STALL in 1st cycle, ack in 2nd;
  - starved write: ack in cycle STARVE_MAX+2.
- Writes to x0: handshake completes normally; the register unit is never written (ru_RUWr = 0); a read of x0 returns the register unit value (0).
- The CPU write is never dropped or altered outside STALL. Blocking it in STALL is legal only because cpu_stall makes the CPU repeat the instruction.

Test Plan:
- Reset: hold rst_n = 0 for 3 cycles with dbg_req = 1 → cpu_stall = 0, dbg_ack = 0, dbg_rdata = 0, no ru_RUWr from debug.
- Free-slot write: cpu_RUWr = 0; dbg write x5 = 0xDEADBEEF → ru_RUWr = 1, ru_rd = 5 in the WAIT cycle; ack 2 cycles after the req edge; cpu_stall never high; a later read of x5 returns 0xDEADBEEF.
- Read: x7 preloaded 0x12345678; dbg read x7 → cpu_stall high exactly 1 cycle with ru_rs2 = 7 and ru_RUWr = 0; dbg_rdata = 0x12345678 at ack.
- Starvation: cpu_RUWr = 1, cpu_rd = 3 every cycle; dbg write x9 = 0xA5 → 8 WAIT cycles with the CPU writing x3, then one STALL cycle writing x9; ack at cycle 10; x3 holds the CPU value.
- x0 write plus race: dbg write x0 = 0xFFFF while the CPU writes x0 → handshake acks, x0 reads 0, no spurious writes.
- Reset mid-op: drop rst_n in the STALL cycle of a read → next cycle IDLE, no ack, cpu_stall 0, dbg_rdata 0.
